mfp_ahb_arbiter: RTL and testbench

- Two-master AHB-Lite arbiter placed between the MIPS core's AHB master port (master 0) and a second bus master (master 1: DMA or loader engine) in front of the single-slave AHB fabric.
- Muxes address and control from the granted master onto the shared slave bus, steers HWDATA by data-phase owner, and returns HREADY/HRESP per master.
- A non-granted master is stalled through its own HREADY.
- Ownership changes only at transfer boundaries where the owner drives IDLE. A saturating stall counter is kept for debug.

---
 rtl/mfp_ahb_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mfp_ahb_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_ahb_arbiter.sv
// mfp_ahb_arbiter
// Two-master AHB-Lite arbiter in front of a single-slave fabric. Master 0 is
// the MIPS core, master 1 a DMA/loader engine. The granted master's address
// phase passes straight through to the slave. Write data, HRESP and HREADY are
// steered by whoever owns the data phase in flight. A requesting master that
// does not own the bus sees HREADY low until it is granted. Ownership moves
// only when the current owner drives an unlocked IDLE and the slave is ready,
// so the outgoing master never has a data phase pending at the switch.
//
// state  | meaning
// OWN_M0 | master 0 owns the address phase
// OWN_M1 | master 1 owns the address phase

module mfp_ahb_arbiter #(
  parameter int DEFAULT_MASTER = 0,
  parameter int STALL_W        = 16
) (
  input  logic               HCLK,
  input  logic               HRESETn,

  input  logic [31:0]        m0_HADDR,
  input  logic [1:0]         m0_HTRANS,
  input  logic               m0_HWRITE,
  input  logic [2:0]         m0_HSIZE,
  input  logic [2:0]         m0_HBURST,
  input  logic [3:0]         m0_HPROT,
  input  logic               m0_HMASTLOCK,
  input  logic [31:0]        m0_HWDATA,
  output logic               m0_HREADY,
  output logic               m0_HRESP,
  output logic [31:0]        m0_HRDATA,

  input  logic [31:0]        m1_HADDR,
  input  logic [1:0]         m1_HTRANS,
  input  logic               m1_HWRITE,
  input  logic [2:0]         m1_HSIZE,
  input  logic [2:0]         m1_HBURST,
  input  logic [3:0]         m1_HPROT,
  input  logic               m1_HMASTLOCK,
  input  logic [31:0]        m1_HWDATA,
  output logic               m1_HREADY,
  output logic               m1_HRESP,
  output logic [31:0]        m1_HRDATA,

  output logic [31:0]        s_HADDR,
  output logic [1:0]         s_HTRANS,
  output logic               s_HWRITE,
  output logic [2:0]         s_HSIZE,
  output logic [2:0]         s_HBURST,
  output logic [3:0]         s_HPROT,
  output logic               s_HMASTLOCK,
  output logic [31:0]        s_HWDATA,
  input  logic [31:0]        s_HRDATA,
  input  logic               s_HREADY,
  input  logic               s_HRESP,

  output logic               grant,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  localparam owner_e             DEF_OWNER = (DEFAULT_MASTER != 0) ? OWN_M1 : OWN_M0;
  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

  owner_e             grant_q, grant_d;
  owner_e             downer_q, downer_d;
  logic               dvalid_q, dvalid_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic               req0, req1;
  logic [1:0]         own_trans;
  logic               own_lock;
  logic               other_req;
  logic               release_bus;
  logic               m0_dphase, m1_dphase;

  // BUSY (01) keeps bit 1 low: it is not a request, yet it still holds the bus
  assign req0 = m0_HTRANS[1];
  assign req1 = m1_HTRANS[1];

  // Owner-side view that decides whether the bus may change hands this cycle
  always_comb begin
    own_trans = m0_HTRANS;
    own_lock  = m0_HMASTLOCK;
    other_req = req1;
    if (grant_q == OWN_M1) begin
      own_trans = m1_HTRANS;
      own_lock  = m1_HMASTLOCK;
      other_req = req0;
    end
    release_bus = s_HREADY && (own_trans == 2'b00) && !own_lock;
  end

  // Next owner: alternate to a waiting master on release, otherwise park
  always_comb begin
    grant_d = grant_q;
    if (release_bus) begin
      if (other_req) begin
        grant_d = (grant_q == OWN_M0) ? OWN_M1 : OWN_M0;
      end else begin
        grant_d = DEF_OWNER;
      end
    end
  end

  // Data-phase ownership advances only when the slave completes a phase
  always_comb begin
    dvalid_d = dvalid_q;
    downer_d = downer_q;
    if (s_HREADY) begin
      dvalid_d = s_HTRANS[1];
      downer_d = grant_q;
    end
  end

  // Saturating count of cycles a non-owner spent waiting for the bus
  always_comb begin
    stall_d = stall_q;
    if (other_req && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  // Arbiter state; reset abandons any data phase in flight
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q  <= DEF_OWNER;
      downer_q <= DEF_OWNER;
      dvalid_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      grant_q  <= grant_d;
      downer_q <= downer_d;
      dvalid_q <= dvalid_d;
      stall_q  <= stall_d;
    end
  end

  // Zero-latency address/control pass-through from the granted master
  always_comb begin
    s_HADDR     = m0_HADDR;
    s_HTRANS    = m0_HTRANS;
    s_HWRITE    = m0_HWRITE;
    s_HSIZE     = m0_HSIZE;
    s_HBURST    = m0_HBURST;
    s_HPROT     = m0_HPROT;
    s_HMASTLOCK = m0_HMASTLOCK;
    if (grant_q == OWN_M1) begin
      s_HADDR     = m1_HADDR;
      s_HTRANS    = m1_HTRANS;
      s_HWRITE    = m1_HWRITE;
      s_HSIZE     = m1_HSIZE;
      s_HBURST    = m1_HBURST;
      s_HPROT     = m1_HPROT;
      s_HMASTLOCK = m1_HMASTLOCK;
    end
  end

  // Write data belongs to the data-phase owner, not the address-phase owner
  assign s_HWDATA = (downer_q == OWN_M1) ? m1_HWDATA : m0_HWDATA;

  // Per-master ready/response: owners see the slave, waiting requesters stall
  always_comb begin
    m0_dphase = dvalid_q && (downer_q == OWN_M0);
    m1_dphase = dvalid_q && (downer_q == OWN_M1);
    m0_HREADY = ((grant_q == OWN_M0) || m0_dphase) ? s_HREADY : ~req0;
    m1_HREADY = ((grant_q == OWN_M1) || m1_dphase) ? s_HREADY : ~req1;
    m0_HRESP  = m0_dphase ? s_HRESP : 1'b0;
    m1_HRESP  = m1_dphase ? s_HRESP : 1'b0;
  end

  assign m0_HRDATA = s_HRDATA;
  assign m1_HRDATA = s_HRDATA;
  assign grant     = grant_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_mfp_ahb_arbiter.sv
// Bench for mfp_ahb_arbiter: directed AHB scenarios, a transaction-level
// reference model checked every cycle, plus literal expectations.

module tb_mfp_ahb_arbiter;

  localparam int SW   = 4;
  localparam int DEF  = 0;
  localparam int SMAX = (1 << SW) - 1;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;

  logic [31:0] m0_HADDR = '0, m1_HADDR = '0;
  logic [1:0]  m0_HTRANS = '0, m1_HTRANS = '0;
  logic        m0_HWRITE = 1'b0, m1_HWRITE = 1'b0;
  logic [2:0]  m0_HSIZE = 3'b010, m1_HSIZE = 3'b010;
  logic [2:0]  m0_HBURST = '0, m1_HBURST = '0;
  logic [3:0]  m0_HPROT = 4'b0011, m1_HPROT = 4'b0001;
  logic        m0_HMASTLOCK = 1'b0, m1_HMASTLOCK = 1'b0;
  logic [31:0] m0_HWDATA = 32'h0000AAAA, m1_HWDATA = 32'h0000BBBB;
  logic        m0_HREADY, m1_HREADY, m0_HRESP, m1_HRESP;
  logic [31:0] m0_HRDATA, m1_HRDATA;

  logic [31:0] s_HADDR, s_HWDATA;
  logic [1:0]  s_HTRANS;
  logic        s_HWRITE, s_HMASTLOCK;
  logic [2:0]  s_HSIZE, s_HBURST;
  logic [3:0]  s_HPROT;
  logic [31:0] s_HRDATA = 32'h12345678;
  logic        s_HREADY = 1'b1;
  logic        s_HRESP = 1'b0;

  logic          grant;
  logic [SW-1:0] stall_cnt;

  mfp_ahb_arbiter #(.DEFAULT_MASTER(DEF), .STALL_W(SW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_HADDR(m0_HADDR), .m0_HTRANS(m0_HTRANS), .m0_HWRITE(m0_HWRITE),
    .m0_HSIZE(m0_HSIZE), .m0_HBURST(m0_HBURST), .m0_HPROT(m0_HPROT),
    .m0_HMASTLOCK(m0_HMASTLOCK), .m0_HWDATA(m0_HWDATA),
    .m0_HREADY(m0_HREADY), .m0_HRESP(m0_HRESP), .m0_HRDATA(m0_HRDATA),
    .m1_HADDR(m1_HADDR), .m1_HTRANS(m1_HTRANS), .m1_HWRITE(m1_HWRITE),
    .m1_HSIZE(m1_HSIZE), .m1_HBURST(m1_HBURST), .m1_HPROT(m1_HPROT),
    .m1_HMASTLOCK(m1_HMASTLOCK), .m1_HWDATA(m1_HWDATA),
    .m1_HREADY(m1_HREADY), .m1_HRESP(m1_HRESP), .m1_HRDATA(m1_HRDATA),
    .s_HADDR(s_HADDR), .s_HTRANS(s_HTRANS), .s_HWRITE(s_HWRITE),
    .s_HSIZE(s_HSIZE), .s_HBURST(s_HBURST), .s_HPROT(s_HPROT),
    .s_HMASTLOCK(s_HMASTLOCK), .s_HWDATA(s_HWDATA),
    .s_HRDATA(s_HRDATA), .s_HREADY(s_HREADY), .s_HRESP(s_HRESP),
    .grant(grant), .stall_cnt(stall_cnt)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_grant    = DEF;   // address-phase owner
  int m_dp_owner = DEF;   // master whose data phase the slave is serving
  bit m_dp_live  = 1'b0;  // that data phase is a real transfer
  int m_stall    = 0;

  function automatic logic [1:0] trans_of(input int n);
    return (n == 1) ? m1_HTRANS : m0_HTRANS;
  endfunction

  function automatic logic lock_of(input int n);
    return (n == 1) ? m1_HMASTLOCK : m0_HMASTLOCK;
  endfunction

  function automatic bit wants(input int n);
    return trans_of(n) >= 2'd2;  // NONSEQ or SEQ
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_grant    = DEF;
      m_dp_owner = DEF;
      m_dp_live  = 1'b0;
      m_stall    = 0;
    end else begin
      if (wants(1 - m_grant) && m_stall < SMAX) m_stall = m_stall + 1;
      if (s_HREADY) begin
        m_dp_live  = wants(m_grant);
        m_dp_owner = m_grant;
      end
      if (s_HREADY && trans_of(m_grant) == 2'b00 && !lock_of(m_grant))
        m_grant = wants(1 - m_grant) ? (1 - m_grant) : DEF;
    end
  end

  function automatic logic exp_ready(input int n);
    if (m_grant == n || (m_dp_live && m_dp_owner == n)) return s_HREADY;
    return !wants(n);
  endfunction

  function automatic logic exp_resp(input int n);
    return (m_dp_live && m_dp_owner == n) ? s_HRESP : 1'b0;
  endfunction

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge HCLK) begin
    chk("grant",       32'(grant),       32'(m_grant));
    chk("stall_cnt",   32'(stall_cnt),   32'(m_stall));
    chk("s_HADDR",     s_HADDR,          (m_grant == 1) ? m1_HADDR : m0_HADDR);
    chk("s_HTRANS",    32'(s_HTRANS),    32'(trans_of(m_grant)));
    chk("s_HWRITE",    32'(s_HWRITE),    32'((m_grant == 1) ? m1_HWRITE : m0_HWRITE));
    chk("s_HSIZE",     32'(s_HSIZE),     32'((m_grant == 1) ? m1_HSIZE : m0_HSIZE));
    chk("s_HBURST",    32'(s_HBURST),    32'((m_grant == 1) ? m1_HBURST : m0_HBURST));
    chk("s_HPROT",     32'(s_HPROT),     32'((m_grant == 1) ? m1_HPROT : m0_HPROT));
    chk("s_HMASTLOCK", 32'(s_HMASTLOCK), 32'(lock_of(m_grant)));
    chk("s_HWDATA",    s_HWDATA,         (m_dp_owner == 1) ? m1_HWDATA : m0_HWDATA);
    chk("m0_HREADY",   32'(m0_HREADY),   32'(exp_ready(0)));
    chk("m1_HREADY",   32'(m1_HREADY),   32'(exp_ready(1)));
    chk("m0_HRESP",    32'(m0_HRESP),    32'(exp_resp(0)));
    chk("m1_HRESP",    32'(m1_HRESP),    32'(exp_resp(1)));
    chk("m0_HRDATA",   m0_HRDATA,        s_HRDATA);
    chk("m1_HRDATA",   m1_HRDATA,        s_HRDATA);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drv0(input logic [1:0] t, input logic [31:0] a, input logic w,
                      input logic [2:0] b, input logic l);
    m0_HTRANS = t; m0_HADDR = a; m0_HWRITE = w; m0_HBURST = b; m0_HMASTLOCK = l;
  endtask

  task automatic drv1(input logic [1:0] t, input logic [31:0] a, input logic w,
                      input logic [2:0] b, input logic l);
    m1_HTRANS = t; m1_HADDR = a; m1_HWRITE = w; m1_HBURST = b; m1_HMASTLOCK = l;
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
    s_HRDATA = s_HRDATA + 32'h01010101;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic rst_pulse();
    HRESETn = 1'b0;
    #1;
    HRESETn = 1'b1;
  endtask

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

  logic [1:0]  burst_t [5] = '{NSEQ, SEQ, BUSY, SEQ, SEQ};
  logic [31:0] burst_a [5] = '{32'h48, 32'h4C, 32'h40, 32'h40, 32'h44};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset with master 0 presenting the boot fetch
    drv0(NSEQ, 32'h1FC00000, 1'b0, 3'b000, 1'b0);
    #1 HRESETn = 1'b0;
    #2;
    chk("rst_grant",     32'(grant),     32'd0);
    chk("rst_s_HADDR",   s_HADDR,        32'h1FC00000);
    chk("rst_m0_HREADY", 32'(m0_HREADY), 32'd1);
    chk("rst_m1_HREADY", 32'(m1_HREADY), 32'd1);
    chk("rst_stall",     32'(stall_cnt), 32'd0);
    chk("rst_m0_HRESP",  32'(m0_HRESP),  32'd0);
    s_HREADY = 1'b0;
    settle();
    chk("rst_m0_follows_slave", 32'(m0_HREADY), 32'd0);
    chk("rst_m1_idle_ready",    32'(m1_HREADY), 32'd1);
    s_HREADY = 1'b1;
    cyc();
    cyc();
    HRESETn = 1'b1;

    // Single write from master 1 after master 0 goes idle
    cyc();
    drv0(IDLE, 32'h1FC00004, 1'b0, 3'b000, 1'b0);
    drv1(NSEQ, 32'h10000000, 1'b1, 3'b000, 1'b0);
    settle();
    chk("t2_m1_waits",  32'(m1_HREADY), 32'd0);
    chk("t2_grant_old", 32'(grant),     32'd0);
    cyc();
    settle();
    chk("t2_grant_new", 32'(grant),     32'd1);
    chk("t2_addr",      s_HADDR,        32'h10000000);
    chk("t2_write",     32'(s_HWRITE),  32'd1);
    chk("t2_m1_ready",  32'(m1_HREADY), 32'd1);
    cyc();
    drv1(IDLE, 32'h10000004, 1'b0, 3'b000, 1'b0);
    m1_HWDATA = 32'hDEADBEEF;
    s_HREADY  = 1'b0;
    settle();
    chk("t2_wdata",      s_HWDATA,       32'hDEADBEEF);
    chk("t2_m1_wait",    32'(m1_HREADY), 32'd0);
    chk("t2_m0_idle_rd", 32'(m0_HREADY), 32'd1);
    cyc();
    s_HREADY = 1'b1;
    settle();
    chk("t2_m1_done",  32'(m1_HREADY), 32'd1);
    chk("t2_wdata2",   s_HWDATA,       32'hDEADBEEF);
    cyc();
    settle();
    chk("t2_park", 32'(grant), 32'd0);

    // Master 0 streams while master 1 waits five cycles
    rst_pulse();
    m1_HWDATA = 32'h0000BBBB;
    drv1(NSEQ, 32'h20000000, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drv0(NSEQ, 32'h100 + 32'(4 * i), 1'b0, 3'b000, 1'b0);
      settle();
      chk("t3_m1_held", 32'(m1_HREADY), 32'd0);
      cyc();
    end
    drv0(IDLE, 32'h110, 1'b0, 3'b000, 1'b0);
    settle();
    chk("t3_m1_held_idle", 32'(m1_HREADY), 32'd0);
    chk("t3_grant_still0", 32'(grant),     32'd0);
    cyc();
    settle();
    chk("t3_stall",       32'(stall_cnt), 32'd5);
    chk("t3_model_stall", 32'(m_stall),   32'd5);
    chk("t3_grant",       32'(grant),     32'd1);
    chk("t3_addr",        s_HADDR,        32'h20000000);
    cyc();
    drv1(IDLE, 32'h20000004, 1'b0, 3'b000, 1'b0);
    cyc();

    // Wrapping burst with a BUSY beat: no switch until IDLE
    drv1(NSEQ, 32'h30000000, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drv0(burst_t[i], burst_a[i], 1'b0, 3'b010, 1'b0);
      settle();
      chk("t4_grant_burst", 32'(grant), 32'd0);
      chk("t4_m1_held",     32'(m1_HREADY), 32'd0);
      cyc();
    end
    drv0(IDLE, 32'h48, 1'b0, 3'b000, 1'b0);
    settle();
    chk("t4_grant_idle", 32'(grant), 32'd0);
    cyc();
    settle();
    chk("t4_grant_switch", 32'(grant),     32'd1);
    chk("t4_stall",        32'(stall_cnt), 32'd11);
    cyc();
    drv1(IDLE, 32'h30000004, 1'b0, 3'b000, 1'b0);
    cyc();

    // Locked sequence holds the bus through an IDLE
    drv1(NSEQ, 32'h40000000, 1'b1, 3'b000, 1'b0);
    drv0(NSEQ, 32'h200, 1'b0, 3'b000, 1'b1);
    cyc();
    drv0(IDLE, 32'h200, 1'b0, 3'b000, 1'b1);
    cyc();
    settle();
    chk("t5_locked_idle", 32'(grant), 32'd0);
    drv0(NSEQ, 32'h204, 1'b1, 3'b000, 1'b1);
    cyc();
    drv0(IDLE, 32'h208, 1'b0, 3'b000, 1'b0);
    settle();
    chk("t5_before_unlock", 32'(grant), 32'd0);
    cyc();
    settle();
    chk("t5_unlocked", 32'(grant),     32'd1);
    chk("t5_stall_sat", 32'(stall_cnt), 32'd15);
    cyc();
    drv1(IDLE, 32'h40000004, 1'b0, 3'b000, 1'b0);
    cyc();

    // Two-cycle ERROR on a master 1 transfer, master 0 waiting
    drv1(NSEQ, 32'h50000000, 1'b0, 3'b000, 1'b0);
    cyc();
    cyc();
    drv1(IDLE, 32'h50000004, 1'b0, 3'b000, 1'b0);
    drv0(NSEQ, 32'h60, 1'b0, 3'b000, 1'b0);
    s_HREADY = 1'b0;
    s_HRESP  = 1'b1;
    settle();
    chk("t6_err1_m1_resp",  32'(m1_HRESP),  32'd1);
    chk("t6_err1_m0_resp",  32'(m0_HRESP),  32'd0);
    chk("t6_err1_m1_ready", 32'(m1_HREADY), 32'd0);
    chk("t6_err1_m0_ready", 32'(m0_HREADY), 32'd0);
    cyc();
    s_HREADY = 1'b1;
    settle();
    chk("t6_err2_m1_resp",  32'(m1_HRESP),  32'd1);
    chk("t6_err2_m0_resp",  32'(m0_HRESP),  32'd0);
    chk("t6_err2_m1_ready", 32'(m1_HREADY), 32'd1);
    chk("t6_err2_grant",    32'(grant),     32'd1);
    cyc();
    s_HRESP = 1'b0;
    settle();
    chk("t6_switch", 32'(grant), 32'd0);
    chk("t6_addr",   s_HADDR,    32'h60);
    cyc();
    drv0(IDLE, 32'h64, 1'b0, 3'b000, 1'b0);

    // Reset pulse in the middle of a master 1 burst
    drv1(NSEQ, 32'h70000000, 1'b0, 3'b011, 1'b0);
    cyc();
    drv0(NSEQ, 32'h80, 1'b0, 3'b000, 1'b0);
    drv1(SEQ, 32'h70000004, 1'b0, 3'b011, 1'b0);
    cyc();
    drv1(SEQ, 32'h70000008, 1'b0, 3'b011, 1'b0);
    settle();
    chk("t7_grant_pre", 32'(grant), 32'd1);
    HRESETn = 1'b0;
    settle();
    chk("t7_rst_grant",    32'(grant),     32'd0);
    chk("t7_rst_stall",    32'(stall_cnt), 32'd0);
    chk("t7_rst_addr",     s_HADDR,        32'h80);
    chk("t7_rst_m1_ready", 32'(m1_HREADY), 32'd0);
    chk("t7_rst_m1_resp",  32'(m1_HRESP),  32'd0);
    cyc();
    settle();
    HRESETn = 1'b1;

    // Stall counter saturation
    drv1(NSEQ, 32'h90000000, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drv0(NSEQ, 32'h300 + 32'(4 * i), 1'b0, 3'b000, 1'b0);
      cyc();
    end
    settle();
    chk("t8_stall_sat",  32'(stall_cnt), 32'd15);
    chk("t8_model_sat",  32'(m_stall),   32'd15);
    drv0(IDLE, 32'h400, 1'b0, 3'b000, 1'b0);
    cyc();
    settle();
    chk("t8_grant", 32'(grant), 32'd1);
    cyc();
    drv1(IDLE, 32'h90000004, 1'b0, 3'b000, 1'b0);
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
